// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage: decodes R/I ops, drives the ALU,
// handshakes multi-cycle mul/div and registers the writeback result.
module alu_issue #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_flush,
  input  logic [6:0]  id_opcode,
  input  logic [2:0]  id_funct3,
  input  logic [6:0]  id_funct7,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  output logic        ex_ready,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        md_valid,
  output logic        md_mode,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        illegal,
  output logic        err_timeout
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  // Abort on the edge where the counter would reach MD_TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = CW'(MD_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, SC, MC_WAIT} state_t;

  state_t        state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          md_valid_q, md_valid_d;
  logic          md_mode_q, md_mode_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          illegal_q, illegal_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       dec_legal;
  logic       dec_is_i;
  logic [4:0] dec_op;
  logic       accept;

  always_comb begin
    dec_legal = 1'b0;
    dec_is_i  = 1'b0;
    dec_op    = OP_ADD;
    case (id_opcode)
      7'b0110011: begin
        case (id_funct7)
          7'b0000000: begin
            dec_legal = 1'b1;
            case (id_funct3)
              3'b000:  dec_op = OP_ADD;
              3'b001:  dec_op = OP_SLL;
              3'b010:  dec_op = OP_SLT;
              3'b011:  dec_op = OP_SLTU;
              3'b100:  dec_op = OP_XOR;
              3'b101:  dec_op = OP_SRL;
              3'b110:  dec_op = OP_OR;
              default: dec_op = OP_AND;
            endcase
          end
          7'b0100000: begin
            if (id_funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_op    = OP_SUB;
            end else if (id_funct3 == 3'b101) begin
              dec_legal = 1'b1;
              dec_op    = OP_SRA;
            end
          end
          7'b0000001: begin
            if (id_funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_op    = OP_MUL;
            end else if (id_funct3 == 3'b100) begin
              dec_legal = 1'b1;
              dec_op    = OP_DIV;
            end
          end
          default: ;
        endcase
      end
      7'b0010011: begin
        dec_legal = 1'b1;
        dec_is_i  = 1'b1;
        case (id_funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = id_imm[10] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      default: ;
    endcase
  end

  assign ex_ready = (state_q != MC_WAIT);
  assign accept   = id_valid & ex_ready & dec_legal & ~id_flush;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    md_valid_d  = md_valid_q;
    md_mode_d   = md_mode_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    illegal_d   = id_valid & ex_ready & ~dec_legal;

    case (state_q)
      SC: begin
        state_d = IDLE;
        if (!id_flush) begin
          res_valid_d = 1'b1;
          res_data_d  = alu_result;
        end
      end
      MC_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (id_flush) begin
          state_d    = IDLE;
          md_valid_d = 1'b0;
        end else if (md_ready) begin
          state_d     = IDLE;
          md_valid_d  = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = md_result;
        end else if (cnt_q == TO_LAST) begin
          state_d    = IDLE;
          md_valid_d = 1'b0;
          err_d      = 1'b1;
        end
      end
      default: ;
    endcase

    // A new accept overrides the SC->IDLE default so single-cycle ops stream.
    if (accept) begin
      op_d = dec_op;
      a_d  = id_rs1_data;
      b_d  = dec_is_i ? id_imm : id_rs2_data;
      if (dec_op == OP_MUL || dec_op == OP_DIV) begin
        state_d    = MC_WAIT;
        md_valid_d = 1'b1;
        md_mode_d  = (dec_op == OP_DIV);
        cnt_d      = '0;
      end else begin
        state_d = SC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      md_valid_q  <= 1'b0;
      md_mode_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      illegal_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      md_valid_q  <= md_valid_d;
      md_mode_q   <= md_mode_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      illegal_q   <= illegal_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign md_valid    = md_valid_q;
  assign md_mode     = md_mode_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign illegal     = illegal_q;
  assign err_timeout = err_q;

endmodule
